// File: rtl/ysyx_24100005_lsu.sv
// ysyx_24100005 load/store unit: valid/ready bridge between the execute stage and data
// memory with byte-lane alignment, load extension, error detection and a response timeout.
module ysyx_24100005_lsu #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [2:0]          req_funct3,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_rdata
);
   // state  | meaning
   // S_IDLE | ready for a core request
   // S_REQ  | memory request presented, waiting for mem_req_ready
   // S_WAIT | waiting for read data / write ack, timeout running
   // S_RESP | response presented, waiting for resp_ready

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               r_we;
   logic [2:0]         r_funct3;
   logic [ADDR_W-1:0]  r_addr;
   logic [DATA_W-1:0]  r_wdata;
   logic [DATA_W-1:0]  r_rdata;
   logic               r_err;

   logic               legal;
   logic               aligned;
   logic [OFF_W-1:0]   off;
   logic [DATA_W-1:0]  shifted;
   logic [DATA_W-1:0]  ext;
   logic [NB-1:0]      lane_mask;

   always_comb begin
      legal = 1'b0;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b011:                 legal = (DATA_W == 64);
         3'b100, 3'b101:         legal = !req_we;
         3'b110:                 legal = !req_we && (DATA_W == 64);
         default:                legal = 1'b0;
      endcase
   end

   always_comb begin
      aligned = 1'b1;
      case (req_funct3[1:0])
         2'b01:   aligned = (req_addr[0] == 1'b0);
         2'b10:   aligned = (req_addr[1:0] == 2'b00);
         2'b11:   aligned = (req_addr[2:0] == 3'b000);
         default: aligned = 1'b1;
      endcase
   end

   assign off     = r_addr[OFF_W-1:0];
   assign shifted = mem_rdata >> {off, 3'b000};

   always_comb begin
      ext = shifted;
      case (r_funct3)
         3'b000:  ext = DATA_W'($signed(shifted[7:0]));
         3'b001:  ext = DATA_W'($signed(shifted[15:0]));
         3'b010:  ext = DATA_W'($signed(shifted[31:0]));
         3'b100:  ext = DATA_W'(shifted[7:0]);
         3'b101:  ext = DATA_W'(shifted[15:0]);
         3'b110:  ext = DATA_W'(shifted[31:0]);
         default: ext = shifted;
      endcase
   end

   always_comb begin
      lane_mask = '1;
      case (r_funct3[1:0])
         2'b00:   lane_mask = NB'(1);
         2'b01:   lane_mask = NB'(3);
         2'b10:   lane_mask = NB'(15);
         default: lane_mask = '1;
      endcase
   end

   // Memory-side fields decode only from the latched request, so they stay stable in S_REQ.
   assign mem_addr      = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign mem_wdata     = r_wdata << {off, 3'b000};
   assign mem_wmask     = r_we ? (lane_mask << off) : '0;
   assign mem_we        = r_we;
   assign mem_req_valid = (state == S_REQ);
   assign req_ready     = (state == S_IDLE);
   assign resp_valid    = (state == S_RESP);
   assign resp_rdata    = r_rdata;
   assign resp_err      = r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         r_we     <= 1'b0;
         r_funct3 <= 3'b000;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we     <= req_we;
                  r_funct3 <= req_funct3;
                  r_addr   <= req_addr;
                  r_wdata  <= req_wdata;
                  r_rdata  <= '0;
                  if (legal && aligned) begin
                     r_err <= 1'b0;
                     state <= S_REQ;
                  end else begin
                     r_err <= 1'b1;
                     state <= S_RESP;
                  end
               end
            end
            S_REQ: begin
               if (mem_req_ready) begin
                  cnt   <= CNT_LOAD;
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_resp_valid) begin
                  r_rdata <= r_we ? '0 : ext;
                  state   <= S_RESP;
               end else if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (TIMEOUT != 0) begin
                  r_err   <= 1'b1;
                  r_rdata <= '0;
                  state   <= S_RESP;
               end
            end
            S_RESP: begin
               if (resp_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
